// File: rtl/uart_line_echo_pkg.sv
// Shared types and constants for the UART line-echo engine.
package uart_line_echo_pkg;

    // Echo transform selected by the MODE parameter.
    typedef enum logic [1:0] {
        ECHO_PLAIN,
        ECHO_UPPER,
        ECHO_REVERSE
    } echo_mode_e;

    // Line-echo FSM states.
    typedef enum logic [1:0] {
        S_FILL,
        S_DRAIN,
        S_TERM
    } echo_state_e;

    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;
    localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;

    // Upper-case an ASCII letter; every other code passes through unchanged.
    function automatic logic [7:0] ascii_to_upper(logic [7:0] c);
        if (c >= ASCII_LOWER_A && c <= ASCII_LOWER_Z) begin
            return c - ASCII_CASE_OFFSET;
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_line_echo_line_buffer.sv
// DEPTH x DATA_BITS line store: synchronous write, asynchronous read so it
// can map onto distributed RAM.
module uart_line_echo_line_buffer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // Write port; no reset so the array stays RAM-inferable.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_line_echo.sv
// Line-buffering echo engine between the uart RX/TX FIFO ports and the send
// button: collects a line, then echoes it (plain, upper-cased or reversed).
module uart_line_echo
    import uart_line_echo_pkg::*;
#(
    parameter int unsigned          DATA_BITS   = 8,
    parameter int unsigned          DEPTH       = 16,
    parameter logic [DATA_BITS-1:0] TERM_CHAR   = DATA_BITS'(8'h0D),
    parameter int unsigned          MODE        = 0,
    parameter int unsigned          APPEND_TERM = 1,
    parameter int unsigned          CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 send_tick_i,
    input  logic                 rx_empty_i,
    input  logic [DATA_BITS-1:0] r_data_i,
    output logic                 rd_uart_o,
    input  logic                 tx_full_i,
    output logic [DATA_BITS-1:0] w_data_o,
    output logic                 wr_uart_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 overflow_o
);

    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]       ModeBits = MODE[1:0];
    localparam echo_mode_e       Mode     = echo_mode_e'(ModeBits);
    localparam bit               Reverse  = (Mode == ECHO_REVERSE);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IdxOne   = IDX_W'(1);

    echo_state_e          state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic                 overflow_q, overflow_d;
    logic                 busy_q;

    logic                 buf_we;
    logic [IDX_W-1:0]     buf_waddr;
    logic [DATA_BITS-1:0] buf_rdata;
    logic                 drain_go;
    logic                 last_char;

    // Applies the MODE transform to a buffered character on its way out.
    function automatic logic [DATA_BITS-1:0] echo_xform(logic [DATA_BITS-1:0] c);
        if (Mode == ECHO_UPPER) begin
            return DATA_BITS'(ascii_to_upper(8'(c)));
        end
        return c;
    endfunction

    // The next free slot is always at index count.
    assign buf_waddr = IDX_W'(count_q);

    uart_line_echo_line_buffer #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .ADDR_W    (IDX_W)
    ) u_line_buffer (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (r_data_i),
        .raddr_i (rd_idx_q),
        .rdata_o (buf_rdata)
    );

    // Reverse mode walks down to 0; forward modes walk up to count-1.
    always_comb begin
        if (Reverse) begin
            last_char = (rd_idx_q == '0);
        end else begin
            last_char = (rd_idx_q == IDX_W'(count_q - CntOne));
        end
    end

    // Next-state, buffer write and FIFO handshake logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_idx_d   = rd_idx_q;
        overflow_d = overflow_q;
        buf_we     = 1'b0;
        drain_go   = 1'b0;
        rd_uart_o  = 1'b0;
        wr_uart_o  = 1'b0;
        w_data_o   = '0;

        unique case (state_q)
            S_FILL: begin
                rd_uart_o = !rx_empty_i;
                if (!rx_empty_i) begin
                    if (r_data_i == TERM_CHAR) begin
                        // Terminator is never stored; an empty line is ignored.
                        drain_go = (count_q != '0);
                    end else if (count_q < DepthCnt) begin
                        buf_we  = 1'b1;
                        count_d = count_q + CntOne;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // count_d already includes a char stored this cycle.
                if (send_tick_i && count_d != '0) begin
                    drain_go = 1'b1;
                end
                if (drain_go) begin
                    state_d  = S_DRAIN;
                    rd_idx_d = Reverse ? IDX_W'(count_d - CntOne) : '0;
                end
            end

            S_DRAIN: begin
                wr_uart_o = !tx_full_i;
                w_data_o  = echo_xform(buf_rdata);
                if (!tx_full_i) begin
                    if (last_char) begin
                        if (APPEND_TERM != 0) begin
                            state_d = S_TERM;
                        end else begin
                            state_d = S_FILL;
                            count_d = '0;
                        end
                    end else begin
                        rd_idx_d = Reverse ? (rd_idx_q - IdxOne) : (rd_idx_q + IdxOne);
                    end
                end
            end

            S_TERM: begin
                wr_uart_o = !tx_full_i;
                w_data_o  = TERM_CHAR;
                if (!tx_full_i) begin
                    state_d = S_FILL;
                    count_d = '0;
                end
            end

            default: begin
                state_d = S_FILL;
                count_d = '0;
            end
        endcase

        // No FIFO traffic while reset is held: a popped char would be discarded.
        if (rst_i) begin
            rd_uart_o = 1'b0;
            wr_uart_o = 1'b0;
        end
    end

    // State, counters and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FILL;
            count_q    <= '0;
            rd_idx_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_idx_q   <= rd_idx_d;
            overflow_q <= overflow_d;
            busy_q     <= (state_d != S_FILL);
        end
    end

    assign busy_o     = busy_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_line_echo.sv
// Self-checking bench: five configurations share one stimulus stream; each has
// its own RX FIFO and a queue-based reference model of the line echo.
module tb_uart_line_echo;

    localparam int NL = 5;
    localparam int unsigned L_MODE [NL] = '{0, 1, 2, 0, 2};
    localparam int unsigned L_DEPTH[NL] = '{16, 16, 16, 4, 5};
    localparam int unsigned L_APP  [NL] = '{1, 1, 1, 1, 0};
    localparam logic [7:0]  TERM = 8'h0D;

    logic clk = 1'b0;
    logic rst;
    logic send_tick;
    logic tx_full;
    logic [NL-1:0]      rx_empty, rd_uart, wr_uart, busy, overflow;
    logic [NL-1:0][7:0] r_data, w_data;
    logic [NL-1:0][4:0] count;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        localparam int unsigned CW = $clog2(L_DEPTH[g] + 1);
        logic [CW-1:0] cnt;
        uart_line_echo #(
            .DATA_BITS   (8),
            .DEPTH       (L_DEPTH[g]),
            .TERM_CHAR   (TERM),
            .MODE        (L_MODE[g]),
            .APPEND_TERM (L_APP[g])
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .send_tick_i (send_tick),
            .rx_empty_i  (rx_empty[g]),
            .r_data_i    (r_data[g]),
            .rd_uart_o   (rd_uart[g]),
            .tx_full_i   (tx_full),
            .w_data_o    (w_data[g]),
            .wr_uart_o   (wr_uart[g]),
            .busy_o      (busy[g]),
            .count_o     (cnt),
            .overflow_o  (overflow[g])
        );
        assign count[g] = 5'(cnt);
    end

    // Reference model state per lane.
    logic [7:0] rxq   [NL][$];
    logic [7:0] line_q[NL][$];
    logic [7:0] out_q [NL][$];
    logic [7:0] got_q [NL][$];
    bit         m_ovf [NL];
    bit         pop_pend[NL];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic string tag(input string n, input int k);
        return $sformatf("%s[%0d]", n, k);
    endfunction

    function automatic logic [7:0] xform(input int unsigned mode, input logic [7:0] c);
        if (mode == 1 && c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
        return c;
    endfunction

    // One clock: check outputs at negedge, advance the model, pop RX after the edge.
    task automatic cycle();
        logic [7:0] c;
        bit go;
        int n;
        for (int k = 0; k < NL; k++) begin
            rx_empty[k] = (rxq[k].size() == 0);
            r_data[k]   = (rxq[k].size() != 0) ? rxq[k][0] : 8'h00;
        end
        @(negedge clk);
        for (int k = 0; k < NL; k++) begin
            pop_pend[k] = 1'b0;
            go = 1'b0;
            if (rst) begin
                line_q[k].delete();
                out_q[k].delete();
                m_ovf[k] = 1'b0;
            end else begin
                if (wr_uart[k]) got_q[k].push_back(w_data[k]);
                check_eq(tag("busy", k), busy[k], out_q[k].size() > 0);
                check_eq(tag("count", k), count[k], line_q[k].size());
                check_eq(tag("overflow", k), overflow[k], m_ovf[k]);
                if (out_q[k].size() == 0) begin
                    check_eq(tag("rd_uart_fill", k), rd_uart[k], rxq[k].size() > 0);
                    check_eq(tag("wr_uart_fill", k), wr_uart[k], 0);
                    if (rxq[k].size() > 0) begin
                        c = rxq[k][0];
                        pop_pend[k] = 1'b1;
                        if (c == TERM) go = (line_q[k].size() > 0);
                        else if (line_q[k].size() < L_DEPTH[k]) line_q[k].push_back(c);
                        else m_ovf[k] = 1'b1;
                    end
                    if (send_tick && line_q[k].size() > 0) go = 1'b1;
                    if (go) begin
                        n = line_q[k].size();
                        for (int i = 0; i < n; i++) begin
                            if (L_MODE[k] == 2) out_q[k].push_back(xform(L_MODE[k], line_q[k][n-1-i]));
                            else out_q[k].push_back(xform(L_MODE[k], line_q[k][i]));
                        end
                        if (L_APP[k] != 0) out_q[k].push_back(TERM);
                    end
                end else begin
                    check_eq(tag("rd_uart_drain", k), rd_uart[k], 0);
                    check_eq(tag("wr_uart_drain", k), wr_uart[k], !tx_full);
                    check_eq(tag("w_data", k), w_data[k], out_q[k][0]);
                    if (!tx_full) begin
                        void'(out_q[k].pop_front());
                        if (out_q[k].size() == 0) line_q[k].delete();
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            if (rst) rxq[k].delete();
            else if (pop_pend[k]) void'(rxq[k].pop_front());
        end
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++)
            for (int k = 0; k < NL; k++) rxq[k].push_back(s[i]);
    endtask

    task automatic feed_c(input logic [7:0] c);
        for (int k = 0; k < NL; k++) rxq[k].push_back(c);
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NL; k++)
            if (rxq[k].size() != 0 || out_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_idle(input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            cycle();
            n++;
        end
        if (!all_idle()) check_eq("idle_timeout", 1, 0);
        repeat (2) cycle();
    endtask

    task automatic wait_pushes(input int k, input int cnt_req, input int budget);
        int n = 0;
        while (got_q[k].size() < cnt_req && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag("push_wait", k), got_q[k].size() >= cnt_req, 1);
    endtask

    task automatic clear_got();
        for (int k = 0; k < NL; k++) got_q[k].delete();
    endtask

    // Compare captured pushes of lane k against the string s (plus TERM if term).
    task automatic check_got(input int k, input string s, input bit term);
        int len;
        logic [7:0] e;
        len = s.len() + (term ? 1 : 0);
        check_eq(tag("got_len", k), got_q[k].size(), len);
        for (int i = 0; i < len && i < got_q[k].size(); i++) begin
            e = (i < s.len()) ? s[i] : TERM;
            check_eq(tag("got_char", k), got_q[k][i], e);
        end
    endtask

    initial begin
        logic [7:0] c;
        rst = 1'b1;
        send_tick = 1'b0;
        tx_full = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // Plain, upper-case and reverse echo of one terminated line.
        clear_got();
        feed("abc"); feed_c(TERM);
        run_idle(100);
        check_got(0, "abc", 1);
        check_got(1, "ABC", 1);
        check_got(2, "cba", 1);
        check_got(4, "cba", 0);

        clear_got();
        feed("aZ9"); feed_c(TERM);
        run_idle(100);
        check_got(1, "AZ9", 1);

        // Line sent by the button instead of the terminator.
        clear_got();
        feed("xyz");
        run_idle(100);
        send_tick = 1'b1;
        cycle();
        send_tick = 1'b0;
        run_idle(100);
        check_got(2, "zyx", 1);

        // Overflow on the DEPTH=4 lane; flag must persist across the next line.
        clear_got();
        feed("abcdef"); feed_c(TERM);
        run_idle(100);
        check_got(3, "abcd", 1);
        clear_got();
        feed("gh"); feed_c(TERM);
        run_idle(100);
        check_got(3, "gh", 1);
        check_eq("overflow_sticky", overflow[3], 1);

        // Backpressure mid-line.
        clear_got();
        feed("01234567"); feed_c(TERM);
        wait_pushes(0, 2, 50);
        tx_full = 1'b1;
        repeat (10) cycle();
        tx_full = 1'b0;
        run_idle(100);
        check_got(0, "01234567", 1);

        // Empty-line cases produce nothing.
        clear_got();
        send_tick = 1'b1;
        cycle();
        send_tick = 1'b0;
        feed_c(TERM);
        run_idle(100);
        check_got(0, "", 0);

        // Tick coincides with the pop of the second character.
        clear_got();
        feed("p");
        run_idle(100);
        feed("q");
        send_tick = 1'b1;
        cycle();
        send_tick = 1'b0;
        run_idle(100);
        check_got(0, "pq", 1);

        // RX traffic during a stalled drain waits in the FIFO.
        clear_got();
        feed("mn"); feed_c(TERM);
        tx_full = 1'b1;
        repeat (6) cycle();
        feed("rs");
        repeat (4) cycle();
        tx_full = 1'b0;
        run_idle(100);
        feed_c(TERM);
        run_idle(100);
        check_got(0, {"mn", 8'h0D, "rs"}, 1);

        // Reset mid-drain aborts the line.
        clear_got();
        feed("ABCDEFGH"); feed_c(TERM);
        wait_pushes(0, 2, 50);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("post_rst_overflow", overflow[3], 0);
        check_eq("post_rst_count", count[0], 0);
        clear_got();
        feed("ok"); feed_c(TERM);
        run_idle(100);
        check_got(0, "ok", 1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            send_tick = ($urandom_range(0, 19) == 0);
            tx_full   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 3) begin
                bit room = 1'b1;
                for (int k = 0; k < NL; k++) if (rxq[k].size() >= 8) room = 1'b0;
                if (room) begin
                    c = ($urandom_range(0, 9) == 0) ? TERM : 8'($urandom_range(8'h30, 8'h7A));
                    feed_c(c);
                end
            end
            cycle();
        end
        send_tick = 1'b0;
        tx_full = 1'b0;
        run_idle(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
